// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-control inputs from the pipeline and stall/flush/status outputs
interface pipeline_hazard_ctrl_if;
  logic        id_valid;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic [3:0]  exe_dest;
  logic        exe_wb_en;
  logic        exe_mem_r_en;
  logic [3:0]  mem_dest;
  logic        mem_wb_en;
  logic        forward_en;
  logic        branch_taken;
  logic        mem_req;
  logic        sram_ready;
  logic        freeze_front;
  logic        freeze_back;
  logic        flush_if;
  logic        flush_id;
  logic        sram_start;
  logic        busy;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;
  logic        mem_timeout;
  modport master (
    output id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, forward_en, branch_taken, mem_req, sram_ready,
    input  freeze_front, freeze_back, flush_if, flush_id, sram_start, busy,
           stall_cycles, flush_count, mem_timeout
  );
  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, forward_en, branch_taken, mem_req, sram_ready,
    output freeze_front, freeze_back, flush_if, flush_id, sram_start, busy,
           stall_cycles, flush_count, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: data-hazard stall, branch flush and memory-wait freeze control with statistics
module pipeline_hazard_ctrl (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;
  logic [0:0] r_state;
  logic [7:0] r_wait_cnt;
  logic       r_timeout;
  logic [15:0] r_stall_cycles;
  logic [7:0]  r_flush_count;
  logic w_m1, w_m2, w_hazard, w_start, w_hold, w_eval;
  function automatic logic src_match(input logic [3:0] src);
    return bus.forward_en ? (bus.exe_mem_r_en && bus.exe_wb_en && (src == bus.exe_dest))
                          : ((bus.exe_wb_en && (src == bus.exe_dest)) || (bus.mem_wb_en && (src == bus.mem_dest)));
  endfunction
  always_comb begin
    w_m1     = src_match(bus.id_src1);
    w_m2     = src_match(bus.id_src2);
    w_hazard = bus.id_valid && (w_m1 || (bus.id_two_src && w_m2));
    w_start  = !rst && (r_state == RUN) && bus.mem_req;
    w_hold   = !rst && (r_state == MEM_WAIT) && !bus.sram_ready;
    w_eval   = !rst && ((r_state == RUN) ? !bus.mem_req : bus.sram_ready);
  end
  assign bus.sram_start   = w_start;
  assign bus.freeze_back  = w_start || w_hold;
  assign bus.freeze_front = w_start || w_hold || (w_eval && !bus.branch_taken && w_hazard);
  assign bus.flush_if     = w_eval && bus.branch_taken;
  assign bus.flush_id     = w_eval && (bus.branch_taken || w_hazard);
  assign bus.busy         = (r_state == MEM_WAIT);
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
  assign bus.mem_timeout  = r_timeout;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state <= w_start ? MEM_WAIT : ((r_state == MEM_WAIT) && bus.sram_ready) ? RUN : r_state;
      if (w_start)
        r_wait_cnt <= '0;
      else if (w_hold && (r_wait_cnt != 8'hFF))
        r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_hold && (r_wait_cnt == 8'hFE))
        r_timeout <= 1'b1;
      if (bus.freeze_front && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (bus.flush_if && (r_flush_count != 8'hFF))
        r_flush_count <= r_flush_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with hand-computed expectations for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  pipeline_hazard_ctrl_if bus ();
  pipeline_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_two_src = 0;
    bus.exe_dest = 0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
    bus.mem_dest = 0; bus.mem_wb_en = 0; bus.forward_en = 0;
    bus.branch_taken = 0; bus.mem_req = 0; bus.sram_ready = 0;
  endtask
  task automatic load_use();
    bus.forward_en = 1; bus.exe_mem_r_en = 1; bus.exe_wb_en = 1;
    bus.exe_dest = 3; bus.id_src1 = 3; bus.id_valid = 1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0] outs();
    return {bus.freeze_front, bus.freeze_back, bus.flush_if, bus.flush_id, bus.sram_start};
  endfunction
  initial begin
    idle();
    bus.mem_req = 1; bus.branch_taken = 1; load_use();
    #1 chk("rst_comb", outs(), 5'b00000);
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.stall_cycles, 0);
    chk("rst_flush", bus.flush_count, 0);
    chk("rst_tmo", bus.mem_timeout, 0);
    rst = 0; idle();
    #1 chk("run_idle", outs(), 5'b00000);
    load_use();
    #1 chk("load_use", outs(), 5'b10010);
    tick();
    chk("load_use_stall", bus.stall_cycles, 1);
    bus.exe_mem_r_en = 0;
    #1 chk("fwd_no_load", outs(), 5'b00000);
    idle();
    bus.mem_wb_en = 1; bus.mem_dest = 5; bus.id_two_src = 1; bus.id_src2 = 5; bus.id_src1 = 7; bus.id_valid = 1;
    #1 chk("nofwd_src2", outs(), 5'b10010);
    tick();
    chk("nofwd_stall", bus.stall_cycles, 2);
    bus.id_two_src = 0;
    #1 chk("nofwd_one_src", outs(), 5'b00000);
    bus.id_two_src = 1; bus.forward_en = 1;
    #1 chk("fwd_mem_match", outs(), 5'b00000);
    tick();
    chk("no_stall_cnt", bus.stall_cycles, 2);
    idle(); load_use(); bus.branch_taken = 1;
    #1 chk("branch_hazard", outs(), 5'b00110);
    tick();
    chk("branch_flush_cnt", bus.flush_count, 1);
    chk("branch_stall_cnt", bus.stall_cycles, 2);
    idle(); bus.mem_req = 1;
    #1 chk("mem_start", outs(), 5'b11001);
    tick();
    chk("mem_busy", bus.busy, 1);
    for (int i = 0; i < 3; i++) begin
      chk("mem_hold", outs(), 5'b11000);
      tick();
    end
    bus.sram_ready = 1;
    #1 chk("mem_ready", outs(), 5'b00000);
    tick();
    chk("mem_back_run", bus.busy, 0);
    chk("mem_stall_cnt", bus.stall_cycles, 6);
    bus.mem_req = 0;
    #1 chk("ready_in_run", outs(), 5'b00000);
    tick();
    chk("ready_in_run_busy", bus.busy, 0);
    bus.sram_ready = 0; bus.mem_req = 1;
    tick();
    bus.mem_req = 0; bus.sram_ready = 1; bus.branch_taken = 1;
    #1 chk("ready_branch", outs(), 5'b00110);
    tick();
    chk("ready_branch_busy", bus.busy, 0);
    chk("ready_branch_flush", bus.flush_count, 2);
    chk("ready_branch_stall", bus.stall_cycles, 7);
    idle(); bus.mem_req = 1;
    tick();
    bus.mem_req = 0;
    repeat (254) tick();
    chk("tmo_254", bus.mem_timeout, 0);
    tick();
    chk("tmo_255", bus.mem_timeout, 1);
    repeat (45) tick();
    chk("tmo_sticky", bus.mem_timeout, 1);
    chk("tmo_busy", bus.busy, 1);
    chk("tmo_stall", bus.stall_cycles, 308);
    bus.mem_req = 1; rst = 1;
    #1 chk("rst_mid_wait", outs(), 5'b00000);
    tick();
    chk("rst_wait_busy", bus.busy, 0);
    chk("rst_wait_tmo", bus.mem_timeout, 0);
    chk("rst_wait_stall", bus.stall_cycles, 0);
    chk("rst_wait_flush", bus.flush_count, 0);
    rst = 0; idle(); load_use();
    repeat (65535) tick();
    chk("stall_reach_max", bus.stall_cycles, 16'hFFFF);
    repeat (4465) tick();
    chk("stall_saturate", bus.stall_cycles, 16'hFFFF);
    idle(); bus.branch_taken = 1;
    repeat (254) tick();
    chk("flush_254", bus.flush_count, 8'hFE);
    repeat (50) tick();
    chk("flush_saturate", bus.flush_count, 8'hFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be as follows.
- clk  in  1  rising-edge clock for all state
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_src1, id_src2  in  4 each  ID source register numbers
- id_two_src  in  1  id_src2 is a real operand (register-operand form, or store)
- exe_dest  in  4  EX-stage destination register
- exe_wb_en, exe_mem_r_en  in  1 each  EX-stage write-back enable and load flag
- mem_dest  in  4  MEM-stage destination register
- mem_wb_en  in  1  MEM-stage write-back enable
- forward_en  in  1  forwarding unit active
- branch_taken  in  1  EX-stage branch resolved taken
- mem_req  in  1  MEM stage holds a load or store
- sram_ready  in  1  memory completed the outstanding access
- freeze_front  out  1  hold PC and IF/ID register
- freeze_back  out  1  hold ID/EX, EX/MEM and MEM/WB registers
- flush_if  out  1  clear IF/ID register
- flush_id  out  1  clear ID/EX register (bubble)
- sram_start  out  1  one-cycle access-start pulse
- busy  out  1  FSM in MEM_WAIT
- stall_cycles  out  16  saturating count of freeze_front cycles
- flush_count  out  8  saturating count of branch flushes
- mem_timeout  out  1  sticky wait-timeout flag

Function
REQ-002 The FSM SHALL have two states: RUN and MEM_WAIT.
REQ-003 Define hazard = id_valid AND (m1 OR (id_two_src AND m2)), where, for src in {id_src1, id_src2}:
- forward_en=1: m = exe_mem_r_en AND exe_wb_en AND src==exe_dest.
- forward_en=0: m = (exe_wb_en AND src==exe_dest) OR (mem_wb_en AND src==mem_dest).
REQ-004 freeze_front, freeze_back, flush_if, flush_id and sram_start SHALL be combinational from state and current inputs (zero-cycle latency).
REQ-005 In RUN with mem_req=1: sram_start=1, freeze_front=1, freeze_back=1, flush_if=0, flush_id=0; next state MEM_WAIT.
REQ-006 In RUN with mem_req=0 and branch_taken=1: flush_if=1, flush_id=1, both freezes 0; branch has priority over hazard.
REQ-007 In RUN with mem_req=0, branch_taken=0 and hazard=1: freeze_front=1, flush_id=1, freeze_back=0, flush_if=0.
REQ-008 In RUN with none of the above, all five outputs SHALL be 0.
REQ-009 In MEM_WAIT with sram_ready=0: freeze_front=1, freeze_back=1, flush_if=0, flush_id=0, sram_start=0; state held.
REQ-010 In MEM_WAIT with sram_ready=1: outputs SHALL equal RUN evaluation with mem_req treated as 0 (REQ-006..008); next state RUN.
REQ-011 sram_ready in RUN SHALL be ignored; sram_start SHALL never be asserted in MEM_WAIT.
REQ-012 busy SHALL be 1 exactly when state is MEM_WAIT.
REQ-013 stall_cycles SHALL increment by 1 on each clock edge where freeze_front=1, saturating at 16'hFFFF.
REQ-014 flush_count SHALL increment on each edge where flush_if=1, saturating at 8'hFF.
REQ-015 An internal 8-bit wait counter SHALL clear on MEM_WAIT entry and increment each MEM_WAIT cycle with sram_ready=0; on reaching 255, mem_timeout SHALL set and remain 1 until reset; the FSM SHALL keep waiting.

Reset
REQ-016 While rst=1, all combinational outputs SHALL be forced to 0 regardless of inputs.
REQ-017 On a clock edge with rst=1: state to RUN, stall_cycles=0, flush_count=0, wait counter=0, mem_timeout=0; this SHALL apply mid-MEM_WAIT with no further sram_start.

Verification
REQ-018 Load-use: forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_valid=1 -> freeze_front=1, flush_id=1 for one cycle; stall_cycles 0->1.
REQ-019 No forwarding: forward_en=0, mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 -> freeze_front=1, flush_id=1; same with id_two_src=0 -> no stall.
REQ-020 Memory wait: mem_req=1 in RUN -> sram_start=1 for 1 cycle, busy=1; sram_ready after 3 cycles -> freezes drop in ready cycle, back to RUN; stall_cycles +4.
REQ-021 Branch plus hazard same cycle: branch_taken=1, hazard=1 -> flush_if=1, flush_id=1, freeze_front=0; flush_count +1.
REQ-022 Timeout: mem_req then sram_ready=0 for 300 cycles -> mem_timeout=1 after 255 wait cycles, busy stays 1; rst=1 -> busy=0, mem_timeout=0, counters 0.
REQ-023 Saturation: force 70000 freeze cycles -> stall_cycles holds 16'hFFFF.
